// File: rtl/decode_de1.sv
// RV32I decoder, DE0 -> DE1, one registered stage.
// Optional RV32M decode enabled by defining DECODE_RV32M_EN.
package decode_de1_pkg;

  typedef logic [31:0] t_rv_instr;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [3:0]  optype;
    logic [4:0]  uop;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        rd_en;
    logic [4:0]  rs1;
    logic        rs1_en;
    logic [4:0]  rs2;
    logic        rs2_en;
    logic [31:0] imm;
  } t_uinstr;

  localparam logic [3:0] OT_ALU_R  = 4'd0;
  localparam logic [3:0] OT_ALU_I  = 4'd1;
  localparam logic [3:0] OT_LOAD   = 4'd2;
  localparam logic [3:0] OT_STORE  = 4'd3;
  localparam logic [3:0] OT_BRANCH = 4'd4;
  localparam logic [3:0] OT_JAL    = 4'd5;
  localparam logic [3:0] OT_JALR   = 4'd6;
  localparam logic [3:0] OT_LUI    = 4'd7;
  localparam logic [3:0] OT_AUIPC  = 4'd8;
  localparam logic [3:0] OT_FENCE  = 4'd9;
  localparam logic [3:0] OT_SYSTEM = 4'd10;

  localparam logic [4:0] UOP_ADD  = 5'd0;
  localparam logic [4:0] UOP_SUB  = 5'd1;
  localparam logic [4:0] UOP_SLL  = 5'd2;
  localparam logic [4:0] UOP_SLT  = 5'd3;
  localparam logic [4:0] UOP_SLTU = 5'd4;
  localparam logic [4:0] UOP_XOR  = 5'd5;
  localparam logic [4:0] UOP_SRL  = 5'd6;
  localparam logic [4:0] UOP_SRA  = 5'd7;
  localparam logic [4:0] UOP_OR   = 5'd8;
  localparam logic [4:0] UOP_AND  = 5'd9;
  localparam logic [4:0] UOP_MUL  = 5'd10;

  localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
  localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

module decode_de1
  import decode_de1_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  t_rv_instr instr_de0,
  output t_uinstr   uinstr_de1
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;
  logic [4:0]  base_uop;
  logic        ill;
  t_uinstr     dec;

  assign opc = instr_de0[6:0];
  assign f3  = instr_de0[14:12];
  assign f7  = instr_de0[31:25];

  assign imm_i  = {{20{instr_de0[31]}}, instr_de0[31:20]};
  assign imm_s  = {{20{instr_de0[31]}}, instr_de0[31:25],
                   instr_de0[11:7]};
  assign imm_b  = {{19{instr_de0[31]}}, instr_de0[31],
                   instr_de0[7], instr_de0[30:25],
                   instr_de0[11:8], 1'b0};
  assign imm_u  = {instr_de0[31:12], 12'b0};
  assign imm_j  = {{11{instr_de0[31]}}, instr_de0[31],
                   instr_de0[19:12], instr_de0[20],
                   instr_de0[30:21], 1'b0};
  assign imm_sh = {27'b0, instr_de0[24:20]};

  // Base ALU op selected by funct3 (funct7-neutral forms)
  always_comb begin
    base_uop = UOP_ADD;
    unique case (f3)
      3'b000: base_uop = UOP_ADD;
      3'b001: base_uop = UOP_SLL;
      3'b010: base_uop = UOP_SLT;
      3'b011: base_uop = UOP_SLTU;
      3'b100: base_uop = UOP_XOR;
      3'b101: base_uop = UOP_SRL;
      3'b110: base_uop = UOP_OR;
      3'b111: base_uop = UOP_AND;
      default: base_uop = UOP_ADD;
    endcase
  end

  // Crack the instruction into a micro-op
  always_comb begin
    dec        = '0;
    ill        = 1'b0;
    dec.valid  = 1'b1;
    dec.funct3 = f3;
    dec.rd     = instr_de0[11:7];
    dec.rs1    = instr_de0[19:15];
    dec.rs2    = instr_de0[24:20];
    unique case (opc)
      OPC_ALU_R: begin
        dec.optype = OT_ALU_R;
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.rd_en  = 1'b1;
        unique case (f7)
          7'h00: dec.uop = base_uop;
          7'h20: begin
            if (f3 == 3'b000)
              dec.uop = UOP_SUB;
            else if (f3 == 3'b101)
              dec.uop = UOP_SRA;
            else
              ill = 1'b1;
          end
`ifdef DECODE_RV32M_EN
          7'h01: dec.uop = UOP_MUL + {2'b0, f3};
`endif
          default: ill = 1'b1;
        endcase
      end
      OPC_ALU_I: begin
        dec.optype = OT_ALU_I;
        dec.rs1_en = 1'b1;
        dec.rd_en  = 1'b1;
        dec.uop    = base_uop;
        dec.imm    = imm_i;
        if (f3 == 3'b001) begin
          dec.imm = imm_sh;
          if (f7 != 7'h00)
            ill = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.imm = imm_sh;
          if (f7 == 7'h20)
            dec.uop = UOP_SRA;
          else if (f7 != 7'h00)
            ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.optype = OT_LOAD;
        dec.rs1_en = 1'b1;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_i;
        ill = (f3 == 3'b011) || (f3 == 3'b110)
           || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.optype = OT_STORE;
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.imm    = imm_s;
        ill = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        dec.optype = OT_BRANCH;
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.imm    = imm_b;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        dec.optype = OT_JAL;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_j;
      end
      OPC_JALR: begin
        dec.optype = OT_JALR;
        dec.rs1_en = 1'b1;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_i;
        ill = (f3 != 3'b000);
      end
      OPC_LUI: begin
        dec.optype = OT_LUI;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_u;
      end
      OPC_AUIPC: begin
        dec.optype = OT_AUIPC;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_u;
      end
      OPC_FENCE: begin
        dec.optype = OT_FENCE;
      end
      OPC_SYSTEM: begin
        dec.optype = OT_SYSTEM;
        dec.imm    = imm_i;
      end
      default: ill = 1'b1;
    endcase
    if (dec.rd == 5'd0)
      dec.rd_en = 1'b0;
    if (ill) begin
      dec.illegal = 1'b1;
      dec.rd_en   = 1'b0;
      dec.rs1_en  = 1'b0;
      dec.rs2_en  = 1'b0;
      dec.uop     = '0;
      dec.imm     = '0;
    end
  end

  // DE1 pipeline register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!reset)
      uinstr_de1 <= '0;
    else
      uinstr_de1 <= dec;
  end

endmodule

// File: tb/tb_decode_de1.sv
// Self-checking bench for decode_de1.
// Random and directed instructions vs. a table-driven model.
module tb_decode_de1;
  import decode_de1_pkg::*;

  logic      clk;
  logic      reset;
  t_rv_instr instr;
  t_uinstr   uinstr;

  int total = 0;
  int bad   = 0;

  t_uinstr expq;

  logic [6:0] optab [11] = '{
    7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
    7'h67, 7'h37, 7'h17, 7'h0F, 7'h73
  };
  int rtab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  decode_de1 dut (
    .clk        (clk),
    .reset      (reset),
    .instr_de0  (instr),
    .uinstr_de1 (uinstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic t_uinstr model(logic [31:0] i);
    t_uinstr u;
    int ot;
    int f3;
    int f7;
    bit ill;
    bit m_en;
    logic [31:0] si;
    u = '0;
    ot = -1;
    for (int k = 0; k < 11; k++)
      if (optab[k] == i[6:0]) ot = k;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    si = i;
`ifdef DECODE_RV32M_EN
    m_en = 1'b1;
`else
    m_en = 1'b0;
`endif
    u.valid  = 1'b1;
    u.funct3 = i[14:12];
    u.rd     = i[11:7];
    u.rs1    = i[19:15];
    u.rs2    = i[24:20];
    ill = (ot < 0);
    u.optype = (ot < 0) ? 4'd0 : 4'(ot);
    if (ot >= 0) begin
      u.rs1_en = ((11'h05F >> ot) & 1) != 0;
      u.rs2_en = ((11'h019 >> ot) & 1) != 0;
      u.rd_en  = (((11'h1E7 >> ot) & 1) != 0)
              && (i[11:7] != 0);
    end
    case (ot)
      0: begin
        if (f7 == 0) u.uop = 5'(rtab[f3]);
        else if (f7 == 32 && f3 == 0) u.uop = 5'd1;
        else if (f7 == 32 && f3 == 5) u.uop = 5'd7;
        else if (f7 == 1 && m_en) u.uop = 5'(10 + f3);
        else ill = 1;
      end
      1: begin
        u.uop = 5'(rtab[f3]);
        if (f3 == 1 || f3 == 5) begin
          u.imm = 32'(i[24:20]);
          if (f3 == 5 && f7 == 32) u.uop = 5'd7;
          else if (f7 != 0) ill = 1;
        end else
          u.imm = 32'($signed(si) >>> 20);
      end
      2: begin
        u.imm = 32'($signed(si) >>> 20);
        ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      3: begin
        u.imm = (32'($signed(si) >>> 25) << 5)
              + 32'(i[11:7]);
        ill = (f3 >= 3);
      end
      4: begin
        u.imm = (32'($signed(si) >>> 31) << 12)
              + (32'(i[7]) << 11)
              + (32'(i[30:25]) << 5)
              + (32'(i[11:8]) << 1);
        ill = (f3 == 2 || f3 == 3);
      end
      5: u.imm = (32'($signed(si) >>> 31) << 20)
               + (32'(i[19:12]) << 12)
               + (32'(i[20]) << 11)
               + (32'(i[30:21]) << 1);
      6: begin
        u.imm = 32'($signed(si) >>> 20);
        ill = (f3 != 0);
      end
      7, 8: u.imm = i & 32'hFFFF_F000;
      10: u.imm = 32'($signed(si) >>> 20);
      default: ;
    endcase
    if (ill) begin
      u.illegal = 1'b1;
      u.rd_en = 0;
      u.rs1_en = 0;
      u.rs2_en = 0;
      u.uop = 0;
      u.imm = 0;
    end
    return u;
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Drive at negedge, confirm output held, check after edge
  task automatic step(string tag, logic [31:0] ins,
                      logic rst);
    @(negedge clk);
    instr = ins;
    reset = rst;
    #1 chk({tag, "_hold"}, uinstr, expq);
    @(posedge clk);
    #1;
    expq = rst ? model(ins) : '0;
    chk(tag, uinstr, expq);
  endtask

  initial begin
    logic [31:0] r;
    logic rst;
    reset = 1'b0;
    instr = 32'h0000_0033;
    expq  = '0;
    @(posedge clk);
    #1 chk("rst1", uinstr, 64'h0);
    step("rst2", 32'h0000_0033, 1'b0);
    chk("rst2_zero", uinstr, 64'h0);

    step("rel", 32'h0000_0033, 1'b1);
    chk("rel_valid", uinstr.valid, 1);
    chk("rel_optype", uinstr.optype, 0);
    chk("rel_uop", uinstr.uop, 0);
    chk("rel_rd_en", uinstr.rd_en, 0);
    chk("rel_rs1_en", uinstr.rs1_en, 1);
    chk("rel_rs2_en", uinstr.rs2_en, 1);

    step("sub", 32'h40B5_0533, 1'b1);
    chk("sub_optype", uinstr.optype, 0);
    chk("sub_uop", uinstr.uop, 1);
    chk("sub_rd", uinstr.rd, 10);
    chk("sub_rd_en", uinstr.rd_en, 1);
    chk("sub_rs1", uinstr.rs1, 10);
    chk("sub_rs2", uinstr.rs2, 11);

    step("addi", 32'hFFC1_0113, 1'b1);
    chk("addi_optype", uinstr.optype, 1);
    chk("addi_uop", uinstr.uop, 0);
    chk("addi_imm", uinstr.imm, 32'hFFFF_FFFC);
    chk("addi_rs2_en", uinstr.rs2_en, 0);

    step("srai", 32'h4050_D093, 1'b1);
    chk("srai_uop", uinstr.uop, 7);
    chk("srai_imm", uinstr.imm, 5);

    step("sw", 32'hFE11_2E23, 1'b1);
    chk("sw_optype", uinstr.optype, 3);
    chk("sw_imm", uinstr.imm, 32'hFFFF_FFFC);
    chk("sw_rd_en", uinstr.rd_en, 0);

    step("jal", 32'h0000_00EF, 1'b1);
    chk("jal_optype", uinstr.optype, 5);
    chk("jal_rd", uinstr.rd, 1);
    chk("jal_rd_en", uinstr.rd_en, 1);
    chk("jal_imm", uinstr.imm, 0);

    step("zero", 32'h0000_0000, 1'b1);
    chk("zero_valid", uinstr.valid, 1);
    chk("zero_ill", uinstr.illegal, 1);
    chk("zero_en",
        {uinstr.rd_en, uinstr.rs1_en, uinstr.rs2_en}, 0);

    step("mul", 32'h02B5_0533, 1'b1);
`ifdef DECODE_RV32M_EN
    chk("mul_uop", uinstr.uop, 10);
    chk("mul_ill", uinstr.illegal, 0);
`else
    chk("mul_ill", uinstr.illegal, 1);
    chk("mul_uop", uinstr.uop, 0);
`endif

    step("lui", 32'h8000_12B7, 1'b1);
    chk("lui_imm", uinstr.imm, 32'h8000_1000);
    step("beq", 32'hFE00_0EE3, 1'b1);
    chk("beq_imm", uinstr.imm, 32'hFFFF_FFFC);
    step("rst_mid", 32'h40B5_0533, 1'b0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if ($urandom_range(0, 15) < 12)
        r[6:0] = optab[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
      rst = ($urandom_range(0, 49) != 0);
      step("rand", r, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_de1.md
# decode_de1

Combinational RV32I instruction decoder with a registered output, sitting between fetch (DE0) and rename/issue (DE1) in the core pipeline. Each cycle it accepts one 32-bit instruction on `instr_de0`, cracks it into a micro-instruction (op class, ALU sub-op, register specifiers and enables, sign-extended immediate, illegal flag) and presents it on `uinstr_de1` one cycle later. There is no stall or handshake; the stage advances every clock.

## Interface
- No parameters.
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- instr_de0  input  32 (t_rv_instr)  raw instruction: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- uinstr_de1  output  t_uinstr (packed)  decoded micro-instruction, fields: valid(1), illegal(1), optype(4), uop(5), funct3(3), rd(5), rd_en(1), rs1(5), rs1_en(1), rs2(5), rs2_en(1), imm(32).

## Operation
- Opcode → optype: 0110011 ALU_R=0, 0010011 ALU_I=1, 0000011 LOAD=2, 0100011 STORE=3, 1100011 BRANCH=4, 1101111 JAL=5, 1100111 JALR=6, 0110111 LUI=7, 0010111 AUIPC=8, 0001111 FENCE=9, 1110011 SYSTEM=10. Any other opcode: illegal=1, optype=0.
- uop (ALU_R/ALU_I only, else 0): ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9; with RV32M: MUL=10 MULH=11 MULHSU=12 MULHU=13 DIV=14 DIVU=15 REM=16 REMU=17.
- ALU_R: funct7 0000000 → by funct3 (000 ADD,001 SLL,010 SLT,011 SLTU,100 XOR,101 SRL,110 OR,111 AND); 0100000 with funct3 000 → SUB, 101 → SRA; other funct7 → illegal.
- ALU_I: same funct3 map; SUB never produced; funct3 001 requires funct7=0000000; funct3 101: funct7 0000000 → SRL, 0100000 → SRA, else illegal.
- Immediates (sign-extended to 32b): I-type for ALU_I/LOAD/JALR/SYSTEM; S for STORE; B for BRANCH (bit0=0); U for LUI/AUIPC (low 12 zero); J for JAL (bit0=0); shift-immediates use imm[4:0]=instr[24:20], upper bits zero; ALU_R/FENCE imm=0.
- Enables: rs1_en for ALU_R, ALU_I, LOAD, STORE, BRANCH, JALR; rs2_en for ALU_R, STORE, BRANCH; rd_en for ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC, and only when rd≠0. Register fields pass through raw regardless of enable.
- funct3 always passes through raw.
- valid=1 for every decoded instruction after reset, including illegal ones; when illegal=1, all enables=0, uop=0, imm=0.
- Illegal funct3: LOAD 011/110/111, STORE ≥011, BRANCH 010/011, JALR ≠000.

## Timing
- Latency exactly 1 cycle: instruction present before edge N appears on uinstr_de1 after edge N.
- Throughput one instruction per cycle; no back-pressure.
- reset=0 at an edge: uinstr_de1 ← all zeros (valid=0) at that edge; first decoded output appears the edge after reset deasserts. Reset wins over any input.
- Output is a pure register; no combinational path from instr_de0 to uinstr_de1.

## Configuration
- DECODE_RV32M_EN defined: ALU_R with funct7=0000001 decodes funct3 000..111 to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (uop 10..17).
- Not defined: funct7=0000001 on ALU_R → illegal=1; uop values 10..17 never produced.

## Test plan
- Hold reset=0 two cycles with 0x00000033 on input → uinstr_de1 all zeros; release → next edge valid=1, optype=0, uop=0, rd_en=0 (rd=x0), rs1_en=rs2_en=1.
- 0x40B50533 (sub a0,a0,a1) → optype=0, uop=1, rd=10 rd_en=1, rs1=10, rs2=11.
- 0xFFC10113 (addi sp,sp,-4) → optype=1, uop=0, imm=0xFFFFFFFC, rs2_en=0; 0x4050D093 (srai x1,x1,5) → uop=7, imm=5.
- 0xFE112E23 (sw x1,-4(sp)) → optype=3, imm=0xFFFFFFFC, rd_en=0; 0x000000EF (jal ra,0) → optype=5, rd=1, rd_en=1, imm=0.
- 0x00000000 → valid=1, illegal=1, all enables 0; back-to-back different instructions each emerge exactly one cycle later.
- 0x02B50533 (mul) → with DECODE_RV32M_EN uop=10, illegal=0; without, illegal=1.
